// File: rtl/stream_adder_driver_if.sv
// Word-level side of the stream adder driver: operand handshake in, result pulse out.
interface stream_adder_driver_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             res_valid;
  logic [WIDTH-1:0] res_sum;

  modport master (
    output in_valid, op_a, op_b,
    input  in_ready, res_valid, res_sum
  );

  modport slave (
    input  in_valid, op_a, op_b,
    output in_ready, res_valid, res_sum
  );
endinterface

// File: rtl/stream_adder_driver.sv
// Serialises an operand pair LSB-first into a bit-serial adder and reassembles
// the returned Sum stream into a word, presented as a one-cycle result pulse.
module stream_adder_driver #(
  parameter int WIDTH   = 8,
  parameter int SUM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_adder_driver_if.slave bus,
  output logic                 A,
  output logic                 B,
  output logic                 adder_rst,
  input  logic                 Sum,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 4);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_SHIFT, S_DRAIN, S_DONE} state_t;

  state_t           state, nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa, sb;
  logic             a_q, b_q;
  logic [WIDTH-1:0] cap, cap_nxt, res_q;
  logic             accept;
  logic             cap_vld;
  logic [IW-1:0]    cap_idx;

  assign accept = (state == S_IDLE) && bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (bus.in_valid) nxt = S_CLR;
      S_CLR:   nxt = S_SHIFT;
      S_SHIFT: if (cnt == CW'(WIDTH - 1)) nxt = (SUM_LAT > 0) ? S_DRAIN : S_DONE;
      S_DRAIN: if (cnt == CW'(SUM_LAT - 1)) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // The rst term keeps the adder's carry cleared whenever this block is in reset.
  always_comb begin
    bus.in_ready  = (state == S_IDLE) && !rst;
    busy          = (state != S_IDLE);
    bus.res_valid = (state == S_DONE);
    adder_rst     = rst || (state == S_CLR);
  end

  // Bit index in SHIFT, latency count in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case (state)
        S_SHIFT: cnt <= (cnt == CW'(WIDTH - 1)) ? '0 : cnt + 1'b1;
        S_DRAIN: cnt <= cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  // ---- stage p0: bit driven this cycle and its index ----
  logic          vld_p0;
  logic [IW-1:0] idx_p0;
  assign vld_p0 = (state == S_SHIFT);
  assign idx_p0 = cnt[IW-1:0];

  // ---- stages p1..pSUM_LAT: align index with the adder's Sum latency ----
  generate
    if (SUM_LAT == 0) begin : g_lat0
      assign cap_vld = vld_p0;
      assign cap_idx = idx_p0;
    end else begin : g_latn
      logic [SUM_LAT-1:0] vld_pipe;
      logic [IW-1:0]      idx_pipe [SUM_LAT];
      always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else begin
          vld_pipe[0] <= vld_p0;
          for (int k = 1; k < SUM_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
      end
      always_ff @(posedge clk) begin
        idx_pipe[0] <= idx_p0;
        for (int k = 1; k < SUM_LAT; k++) idx_pipe[k] <= idx_pipe[k-1];
      end
      assign cap_vld = vld_pipe[SUM_LAT-1];
      assign cap_idx = idx_pipe[SUM_LAT-1];
    end
  endgenerate

  // The last Sum bit lands on the same edge that enters DONE, so res takes cap_nxt.
  always_comb begin
    cap_nxt = cap;
    if (cap_vld) cap_nxt[cap_idx] = Sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      a_q   <= 1'b0;
      b_q   <= 1'b0;
      cap   <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        sa <= bus.op_a;
        sb <= bus.op_b;
      end else if (nxt == S_SHIFT) begin
        sa <= sa >> 1;
        sb <= sb >> 1;
      end
      a_q <= (nxt == S_SHIFT) ? sa[0] : 1'b0;
      b_q <= (nxt == S_SHIFT) ? sb[0] : 1'b0;
      cap <= cap_nxt;
      if (nxt == S_DONE) res_q <= cap_nxt;
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign bus.res_sum = res_q;

endmodule

// File: tb/tb_stream_adder_driver.sv
// Directed bench: one driver paired with a registered serial adder (SUM_LAT=1),
// one with a combinational serial adder (SUM_LAT=0).
module tb_stream_adder_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  stream_adder_driver_if #(.WIDTH(8)) if1 ();
  stream_adder_driver_if #(.WIDTH(8)) if0 ();

  logic a1, b1, ar1, s1, busy1;
  logic a0, b0, ar0, s0, busy0;

  stream_adder_driver #(.WIDTH(8), .SUM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1), .A(a1), .B(b1),
    .adder_rst(ar1), .Sum(s1), .busy(busy1)
  );

  stream_adder_driver #(.WIDTH(8), .SUM_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0), .A(a0), .B(b0),
    .adder_rst(ar0), .Sum(s0), .busy(busy0)
  );

  // Registered bit-serial adder: Sum appears one cycle after A/B.
  logic c1;
  always @(posedge clk) begin
    if (ar1) begin
      c1 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s1 <= a1 ^ b1 ^ c1;
      c1 <= (a1 & b1) | (a1 & c1) | (b1 & c1);
    end
  end

  // Combinational bit-serial adder with a registered carry.
  logic c0;
  assign s0 = a0 ^ b0 ^ c0;
  always @(posedge clk) begin
    if (ar0) c0 <= 1'b0;
    else     c0 <= (a0 & b0) | (a0 & c0) | (b0 & c0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_rv(input int sel);
    return (sel == 1) ? if1.res_valid : if0.res_valid;
  endfunction

  // Issue one word from IDLE; check result latency (cycles after the accept cycle) and value.
  task automatic run_word(input int sel, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp, input int lat, input string tag);
    int n;
    if (sel == 1) begin
      if1.in_valid = 1'b1; if1.op_a = a; if1.op_b = b;
      chk({tag, "_ready"}, if1.in_ready, 1);
    end else begin
      if0.in_valid = 1'b1; if0.op_a = a; if0.op_b = b;
      chk({tag, "_ready"}, if0.in_ready, 1);
    end
    step();
    if1.in_valid = 1'b0;
    if0.in_valid = 1'b0;
    n = 1;
    while (!get_rv(sel) && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_sum"}, (sel == 1) ? if1.res_sum : if0.res_sum, exp);
    step();
    chk({tag, "_pulse"}, get_rv(sel), 0);
  endtask

  initial begin
    logic [7:0] a_str;
    logic [7:0] b_str;
    logic [7:0] pa [3];
    logic [7:0] pb [3];
    logic [7:0] px [3];
    int         acc [3];
    int         n;
    logic       bad;

    rst = 1'b1;
    if1.in_valid = 1'b0; if1.op_a = '0; if1.op_b = '0;
    if0.in_valid = 1'b0; if0.op_a = '0; if0.op_b = '0;
    step();
    step();

    chk("rst_in_ready",  if1.in_ready, 0);
    chk("rst_adder_rst", ar1, 1);
    chk("rst_A",         a1, 0);
    chk("rst_B",         b1, 0);
    chk("rst_busy",      busy1, 0);
    chk("rst_res_valid", if1.res_valid, 0);
    chk("rst_res_sum",   if1.res_sum, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready",     if1.in_ready, 1);
    chk("post_rst_adder_rst", ar1, 0);

    // Basic add 0x35 + 0x4A with explicit serial stream checks.
    a_str = 8'b10101100;
    b_str = 8'b01010010;
    if1.in_valid = 1'b1; if1.op_a = 8'h35; if1.op_b = 8'h4A;
    step();
    if1.in_valid = 1'b0;
    chk("clr_adder_rst", ar1, 1);
    chk("clr_A",         a1, 0);
    chk("clr_busy",      busy1, 1);
    chk("clr_ready",     if1.in_ready, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("basic_A%0d", i), a1, a_str[7-i]);
      chk($sformatf("basic_B%0d", i), b1, b_str[7-i]);
    end
    step();
    chk("basic_c10_valid", if1.res_valid, 0);
    chk("basic_c10_A",     a1, 0);
    step();
    chk("basic_c11_valid", if1.res_valid, 1);
    chk("basic_c11_sum",   if1.res_sum, 8'h7F);
    step();
    chk("basic_c12_valid", if1.res_valid, 0);
    chk("basic_c12_ready", if1.in_ready, 1);
    chk("basic_hold_sum",  if1.res_sum, 8'h7F);

    // Carry chain, wrap and carry clearing between words.
    run_word(1, 8'hFF, 8'h01, 8'h00, 11, "wrap_ff01");
    run_word(1, 8'h80, 8'h80, 8'h00, 11, "wrap_8080");
    run_word(1, 8'h0F, 8'h01, 8'h10, 11, "carry_0f01");

    // Back-to-back with in_valid held high.
    pa[0] = 8'h01; pb[0] = 8'h02; px[0] = 8'h03;
    pa[1] = 8'h10; pb[1] = 8'h20; px[1] = 8'h30;
    pa[2] = 8'hAA; pb[2] = 8'h55; px[2] = 8'hFF;
    bad = 1'b0;
    if1.in_valid = 1'b1;
    for (int w = 0; w < 3; w++) begin
      if1.op_a = pa[w]; if1.op_b = pb[w];
      n = 0;
      while (!if1.in_ready && n < 30) begin
        step();
        n++;
      end
      chk($sformatf("b2b_wait%0d", w), (n < 30), 1);
      acc[w] = cyc;
      step();
      if (w < 2) begin
        if1.op_a = pa[w+1]; if1.op_b = pb[w+1];
      end
      n = 0;
      while (!if1.res_valid && n < 30) begin
        if (if1.in_ready) bad = 1'b1;
        step();
        n++;
      end
      chk($sformatf("b2b_sum%0d", w), if1.res_sum, px[w]);
      if (w == 2) if1.in_valid = 1'b0;
    end
    step();
    chk("b2b_gap01", acc[1] - acc[0], 12);
    chk("b2b_gap12", acc[2] - acc[1], 12);
    chk("b2b_ready_low_busy", bad, 0);

    // Operand and in_valid changes during SHIFT are ignored.
    if1.in_valid = 1'b1; if1.op_a = 8'h21; if1.op_b = 8'h13;
    step();
    step();
    step();
    step();
    if1.op_a = 8'hFF; if1.op_b = 8'hFF;
    step();
    chk("ign_A_shift3", a1, 0);
    step();
    if1.in_valid = 1'b0;
    n = 6;
    while (!if1.res_valid && n < 30) begin
      step();
      n++;
    end
    chk("ign_lat", n, 11);
    chk("ign_sum", if1.res_sum, 8'h34);
    step();
    chk("ign_idle1", busy1, 0);
    step();
    chk("ign_idle2", busy1, 0);

    // Reset in shift cycle 4 of 0x12 + 0x34.
    if1.in_valid = 1'b1; if1.op_a = 8'h12; if1.op_b = 8'h34;
    step();
    if1.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    #1;
    chk("mid_rst_adder_rst", ar1, 1);
    chk("mid_rst_ready",     if1.in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_A",     a1, 0);
    chk("mid_rst_B",     b1, 0);
    chk("mid_rst_busy",  busy1, 0);
    chk("mid_rst_valid", if1.res_valid, 0);
    chk("mid_rst_sum",   if1.res_sum, 0);
    chk("mid_rst_ready_after", if1.in_ready, 1);
    bad = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (if1.res_valid) bad = 1'b1;
    end
    chk("mid_rst_no_pulse", bad, 0);
    run_word(1, 8'h12, 8'h34, 8'h46, 11, "after_rst");

    // Combinational adder build.
    run_word(0, 8'hC3, 8'h3C, 8'hFF, 10, "lat0");
    chk("lat0_busy_idle", busy0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
